// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard unit.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned FWD_SEL_W  = 2;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE     = 1'b0,
    LD_STALL = 1'b1
  } hz_state_e;

  // One-hot register mask for scoreboard set/clear.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source forwarding mux select for the execute stage.
// Ports:
//   rs                  execute-stage source register
//   rd_m / regwrite_m   memory-stage destination and write flag
//   rd_w / regwrite_w   writeback-stage destination and write flag
//   sel                 00 RF, 01 MEM, 10 WB (MEM has priority)
module fwd_select
  import hazard_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  regwrite_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_w,
  output logic [FWD_SEL_W-1:0]  sel
);

  always_comb begin
    sel = FWD_RF;
    if (FWD_EN) begin
      if (regwrite_m && rd_m != '0 && rd_m == rs) begin
        sel = FWD_MEM;
      end else if (regwrite_w && rd_w != '0 && rd_w == rs) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use / RAW / scoreboard /
// structural stalls, and branch flushes.
// Ports:
//   clk, rst                  clock, async active-high reset
//   rs_d, rs_used_d           decode sources and their valid bits
//   rs_e                      execute sources (forwarding)
//   rd_e, memread_e, regwrite_e   execute destination / load / write
//   rd_m, regwrite_m, rd_w, regwrite_w   MEM / WB destinations
//   mc_d                      decode holds a multi-cycle op
//   mc_issue, mc_rd           multi-cycle op enters the unit
//   mc_wb, mc_wb_rd           multi-cycle result written back
//   branch_taken_e            taken branch resolved in EX
//   fwd_sel                   per-source forwarding select
//   stall_f, stall_d, flush_d, flush_e   pipeline control
//   sb_busy                   pending multi-cycle write per register
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FWD_EN   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]   rs_d,
  input  logic [NUM_SRC-1:0]                   rs_used_d,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]   rs_e,
  input  logic [REG_ADDR_W-1:0]                rd_e,
  input  logic                                 memread_e,
  input  logic                                 regwrite_e,
  input  logic [REG_ADDR_W-1:0]                rd_m,
  input  logic                                 regwrite_m,
  input  logic [REG_ADDR_W-1:0]                rd_w,
  input  logic                                 regwrite_w,
  input  logic                                 mc_d,
  input  logic                                 mc_issue,
  input  logic [REG_ADDR_W-1:0]                mc_rd,
  input  logic                                 mc_wb,
  input  logic [REG_ADDR_W-1:0]                mc_wb_rd,
  input  logic                                 branch_taken_e,
  output logic [NUM_SRC-1:0][FWD_SEL_W-1:0]    fwd_sel,
  output logic                                 stall_f,
  output logic                                 stall_d,
  output logic                                 flush_d,
  output logic                                 flush_e,
  output logic [NUM_REGS-1:0]                  sb_busy
);

  // Counter preload; the LOAD_LAT=1 branch is never used.
  localparam logic [CNT_W-1:0] CNT_INIT = (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

  hz_state_e           state;
  logic [CNT_W-1:0]    cnt;
  logic                load_use;
  logic                raw_hz;
  logic                sb_hz;
  logic                struct_hz;
  logic                stall;
  logic [NUM_REGS-1:0] sb_set;
  logic [NUM_REGS-1:0] sb_clr;
  logic [NUM_REGS-1:0] sb_next;

  // Forwarding selects, one instance per source operand.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_select #(
      .FWD_EN (FWD_EN != 0)
    ) u_fwd (
      .rs         (rs_e[i]),
      .rd_m       (rd_m),
      .regwrite_m (regwrite_m),
      .rd_w       (rd_w),
      .regwrite_w (regwrite_w),
      .sel        (fwd_sel[i])
    );
  end

  // Decode-stage hazard detection over all used, nonzero sources.
  always_comb begin
    load_use = 1'b0;
    raw_hz   = 1'b0;
    sb_hz    = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (rs_used_d[i] && rs_d[i] != '0) begin
        if (memread_e && rd_e == rs_d[i]) load_use = 1'b1;
        if (sb_busy[rs_d[i]]) sb_hz = 1'b1;
        if ((regwrite_e && rd_e == rs_d[i]) ||
            (regwrite_m && rd_m == rs_d[i]) ||
            (regwrite_w && rd_w == rs_d[i])) raw_hz = 1'b1;
      end
    end
    // With forwarding enabled, plain RAW dependencies are bypassed.
    if (FWD_EN != 0) raw_hz = 1'b0;
  end

  assign struct_hz = mc_d && ((|sb_busy) || mc_issue);

  // Branch overrides every stall; controls are quiet during reset.
  assign stall   = !rst && !branch_taken_e &&
                   (load_use || state == LD_STALL || sb_hz || struct_hz || raw_hz);
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_d = !rst && branch_taken_e;
  assign flush_e = stall || (!rst && branch_taken_e);

  // Scoreboard next value: set wins over clear, x0 never busy.
  always_comb begin
    sb_set     = (mc_issue && mc_rd != '0) ? reg_onehot(mc_rd) : '0;
    sb_clr     = mc_wb ? reg_onehot(mc_wb_rd) : '0;
    sb_next    = (sb_busy & ~sb_clr) | sb_set;
    sb_next[0] = 1'b0;
  end

  // Load-stall FSM and scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sb_busy <= '0;
    end else begin
      sb_busy <= sb_next;
      if (branch_taken_e) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (load_use && LOAD_LAT > 1) begin
              state <= LD_STALL;
              cnt   <= CNT_INIT;
            end
          end
          LD_STALL: begin
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - CNT_W'(1);
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: main instance with LOAD_LAT=3 and
// forwarding, second instance with LOAD_LAT=1 and forwarding disabled.
module tb_hazard_unit;

  logic             clk;
  logic             rst;
  logic [1:0][4:0]  rs_d;
  logic [1:0]       rs_used_d;
  logic [1:0][4:0]  rs_e;
  logic [4:0]       rd_e, rd_m, rd_w, mc_rd, mc_wb_rd;
  logic             memread_e, regwrite_e, regwrite_m, regwrite_w;
  logic             mc_d, mc_issue, mc_wb, branch_taken_e;

  logic [1:0][1:0]  fwd_sel, nf_fwd_sel;
  logic             stall_f, stall_d, flush_d, flush_e;
  logic             nf_stall_f, nf_stall_d, nf_flush_d, nf_flush_e;
  logic [31:0]      sb_busy, nf_sb_busy;
  logic [3:0]       ctl, nf_ctl;

  int nvec = 0;
  int nerr = 0;

  assign ctl    = {stall_f, stall_d, flush_d, flush_e};
  assign nf_ctl = {nf_stall_f, nf_stall_d, nf_flush_d, nf_flush_e};

  hazard_unit #(.NUM_SRC(2), .LOAD_LAT(3), .FWD_EN(1)) u_dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rs_used_d(rs_used_d), .rs_e(rs_e),
    .rd_e(rd_e), .memread_e(memread_e), .regwrite_e(regwrite_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .mc_d(mc_d), .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_wb(mc_wb),
    .mc_wb_rd(mc_wb_rd), .branch_taken_e(branch_taken_e), .fwd_sel(fwd_sel),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .sb_busy(sb_busy)
  );

  hazard_unit #(.NUM_SRC(2), .LOAD_LAT(1), .FWD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rs_used_d(rs_used_d), .rs_e(rs_e),
    .rd_e(rd_e), .memread_e(memread_e), .regwrite_e(regwrite_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .mc_d(mc_d), .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_wb(mc_wb),
    .mc_wb_rd(mc_wb_rd), .branch_taken_e(branch_taken_e), .fwd_sel(nf_fwd_sel),
    .stall_f(nf_stall_f), .stall_d(nf_stall_d), .flush_d(nf_flush_d),
    .flush_e(nf_flush_e), .sb_busy(nf_sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = '0; rs_used_d = '0; rs_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0; mc_rd = '0; mc_wb_rd = '0;
    memread_e = 1'b0; regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
    mc_d = 1'b0; mc_issue = 1'b0; mc_wb = 1'b0; branch_taken_e = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Hazards present during reset: controls quiet, forwarding still live.
    rd_m = 5'd5; regwrite_m = 1'b1; rs_e[0] = 5'd5;
    memread_e = 1'b1; rd_e = 5'd7; rs_d[1] = 5'd7; rs_used_d = 2'b10; mc_d = 1'b1;
    #2;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_nf_ctl", 32'(nf_ctl), 32'h0);
    chk("rst_sb", sb_busy, 32'h0);
    chk("rst_fwd0", 32'(fwd_sel[0]), 32'h1);
    tick(); tick();
    clear_inputs();
    rst = 1'b0;
    tick();
    chk("idle_ctl", 32'(ctl), 32'h0);

    // Forwarding priority and cases.
    rd_m = 5'd5; regwrite_m = 1'b1; rd_w = 5'd5; regwrite_w = 1'b1; rs_e[0] = 5'd5;
    #1;
    chk("fwd0_mem", 32'(fwd_sel[0]), 32'h1);
    chk("fwd1_rf", 32'(fwd_sel[1]), 32'h0);
    chk("nf_fwd0", 32'(nf_fwd_sel[0]), 32'h0);
    rd_m = 5'd0; #1;
    chk("fwd0_wb", 32'(fwd_sel[0]), 32'h2);
    rd_w = 5'd3; #1;
    chk("fwd0_rf", 32'(fwd_sel[0]), 32'h0);
    rd_w = 5'd6; rs_e[1] = 5'd6; #1;
    chk("fwd1_wb", 32'(fwd_sel[1]), 32'h2);
    regwrite_w = 1'b0; #1;
    chk("fwd1_nowr", 32'(fwd_sel[1]), 32'h0);
    clear_inputs();

    // RAW without load: bypassed with forwarding, stalls without it.
    rs_d[0] = 5'd5; rs_used_d = 2'b01; rd_m = 5'd5; regwrite_m = 1'b1; #1;
    chk("raw_fwd_ctl", 32'(ctl), 32'h0);
    chk("raw_nf_ctl", 32'(nf_ctl), 32'hD);
    rs_used_d = 2'b00; #1;
    chk("raw_unused_nf", 32'(nf_ctl), 32'h0);
    clear_inputs();
    tick();

    // Load-use with LOAD_LAT=3: exactly three stall cycles.
    memread_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd7; rs_d[1] = 5'd7; rs_used_d = 2'b10;
    #1;
    chk("ld_c1", 32'(ctl), 32'hD);
    chk("ld_nf_c1", 32'(nf_ctl), 32'hD);
    tick();
    memread_e = 1'b0; regwrite_e = 1'b0; rd_e = 5'd0; #1;
    chk("ld_c2", 32'(ctl), 32'hD);
    chk("ld_nf_c2", 32'(nf_ctl), 32'h0);
    tick();
    chk("ld_c3", 32'(ctl), 32'hD);
    tick();
    chk("ld_done", 32'(ctl), 32'h0);
    clear_inputs();

    // Load-use with a taken branch in the same cycle.
    memread_e = 1'b1; rd_e = 5'd7; rs_d[1] = 5'd7; rs_used_d = 2'b10; branch_taken_e = 1'b1;
    #1;
    chk("ldbr_ctl", 32'(ctl), 32'h3);
    tick();
    clear_inputs(); #1;
    chk("ldbr_after", 32'(ctl), 32'h0);

    // Scoreboard hazard on x9.
    mc_issue = 1'b1; mc_rd = 5'd9; rs_d[0] = 5'd9; rs_used_d = 2'b01; #1;
    chk("sb_issue_ctl", 32'(ctl), 32'h0);
    tick();
    mc_issue = 1'b0; #1;
    chk("sb_set", sb_busy, 32'h0000_0200);
    chk("sb_stall1", 32'(ctl), 32'hD);
    tick();
    mc_wb = 1'b1; mc_wb_rd = 5'd9; #1;
    chk("sb_stall_wb", 32'(ctl), 32'hD);
    tick();
    mc_wb = 1'b0; #1;
    chk("sb_clr", sb_busy, 32'h0);
    chk("sb_released", 32'(ctl), 32'h0);
    clear_inputs();

    // Set beats clear; rd 0 issue leaves scoreboard alone; structural stall.
    mc_issue = 1'b1; mc_rd = 5'd4; mc_wb = 1'b1; mc_wb_rd = 5'd4;
    tick();
    chk("sb_setwins", sb_busy, 32'h0000_0010);
    mc_wb = 1'b0; mc_rd = 5'd0;
    tick();
    chk("sb_x0", sb_busy, 32'h0000_0010);
    mc_issue = 1'b0; mc_d = 1'b1; #1;
    chk("struct_busy", 32'(ctl), 32'hD);
    mc_d = 1'b0; mc_wb = 1'b1; mc_wb_rd = 5'd4;
    tick();
    mc_wb = 1'b0; mc_d = 1'b1; #1;
    chk("struct_free", 32'(ctl), 32'h0);
    mc_issue = 1'b1; #1;
    chk("struct_issue", 32'(ctl), 32'hD);
    clear_inputs();

    // Scoreboard updates under a branch flush, then reset mid-LD_STALL.
    mc_issue = 1'b1; mc_rd = 5'd9; branch_taken_e = 1'b1; #1;
    chk("br_ctl", 32'(ctl), 32'h3);
    tick();
    clear_inputs(); #1;
    chk("br_sb", sb_busy, 32'h0000_0200);
    memread_e = 1'b1; rd_e = 5'd7; rs_d[1] = 5'd7; rs_used_d = 2'b10; #1;
    chk("rld_c1", 32'(ctl), 32'hD);
    tick();
    memread_e = 1'b0; rd_e = 5'd0; #1;
    chk("rld_c2", 32'(ctl), 32'hD);
    tick();
    chk("rld_c3", 32'(ctl), 32'hD);
    rst = 1'b1; #1;
    chk("rld_rst_ctl", 32'(ctl), 32'h0);
    chk("rld_rst_sb", sb_busy, 32'h0);
    tick();
    rst = 1'b0; #1;
    chk("rld_rel_ctl", 32'(ctl), 32'h0);
    chk("rld_rel_sb", sb_busy, 32'h0);
    tick();
    chk("rld_idle", 32'(ctl), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter NUM_SRC, 2: number of source operands per instruction.
REQ-002 Parameter LOAD_LAT, 1: load-use stall cycles (1..4).
REQ-003 Parameter FWD_EN, 1: 1 enables forwarding; 0 resolves every RAW hazard by stall.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rs_d  in  NUM_SRC x 5  decode-stage source registers.
REQ-008 rs_used_d  in  NUM_SRC  per-source valid in decode.
REQ-009 rs_e  in  NUM_SRC x 5  execute-stage source registers.
REQ-010 rd_e, memread_e, regwrite_e  in  5/1/1  execute-stage destination, load flag, write flag.
REQ-011 rd_m, regwrite_m / rd_w, regwrite_w  in  5/1 each  memory/writeback destination and write flag.
REQ-012 mc_d  in  1  decode holds a multi-cycle (mul/div) op.
REQ-013 mc_issue, mc_rd  in  1/5  multi-cycle op leaves EX into the unit.
REQ-014 mc_wb, mc_wb_rd  in  1/5  multi-cycle result written to register file.
REQ-015 branch_taken_e  in  1  taken branch/jump resolved in EX.
REQ-016 fwd_sel  out  NUM_SRC x 2  per source: 00 RF, 01 MEM, 10 WB.
REQ-017 stall_f, stall_d, flush_d, flush_e  out  1 each  pipeline control.
REQ-018 sb_busy  out  32  scoreboard, bit r = pending multi-cycle write to xr.

Function
REQ-019 fwd_sel[i] SHALL be 01 if regwrite_m, rd_m!=0, rd_m==rs_e[i]; else 10 if regwrite_w, rd_w!=0, rd_w==rs_e[i]; else 00; combinational, MEM priority over WB.
REQ-020 With FWD_EN=0, fwd_sel SHALL be 00 always and any rs_d[i] (used, nonzero) matching a writing rd_e/rd_m/rd_w SHALL stall.
REQ-021 Load-use hazard: memread_e, rd_e!=0, rd_e==rs_d[i] with rs_used_d[i] -> stall_f=stall_d=flush_e=1 that cycle.
REQ-022 FSM states IDLE, LD_STALL; LOAD_LAT>1 -> on load-use from IDLE, enter LD_STALL with counter=LOAD_LAT-2, hold stall and flush_e each cycle, decrement, return to IDLE after counter 0 cycle; total stall = LOAD_LAT cycles.
REQ-023 LOAD_LAT=1 SHALL never enter LD_STALL.
REQ-024 Scoreboard: mc_issue with mc_rd!=0 sets sb_busy[mc_rd] next edge; mc_wb clears sb_busy[mc_wb_rd] next edge; same register set and clear in one cycle -> set wins; bit 0 always 0.
REQ-025 Scoreboard hazard: any used rs_d[i] with sb_busy set -> stall_f=stall_d=flush_e=1.
REQ-026 Structural hazard: mc_d while any sb_busy bit set or mc_issue -> stall.
REQ-027 branch_taken_e -> flush_d=flush_e=1, stall_f=stall_d=0, FSM forced to IDLE, counter cleared; branch overrides every stall.
REQ-028 Scoreboard updates SHALL proceed during stalls and flushes.

Reset
REQ-029 rst SHALL clear sb_busy to 0, FSM to IDLE, counter to 0 immediately.
REQ-030 While rst is high stall_f, stall_d, flush_d, flush_e SHALL be 0; fwd_sel remains combinational.
REQ-031 Reset mid-LD_STALL SHALL abort the stall; first cycle after release is IDLE.

Structure
REQ-032 Package hazard_pkg SHALL hold fwd_sel_e (FWD_RF, FWD_MEM, FWD_WB), hz_state_e, REG_ADDR_W=5, NUM_REGS=32.
REQ-033 Per-source forwarding SHALL be sub-module fwd_select, instantiated NUM_SRC times by generate.

Verification
REQ-034 rd_m=5 regwrite_m, rd_w=5 regwrite_w, rs_e[0]=5 -> fwd_sel[0]=01; rd_m=0 -> 10 if rd_w=5 else 00.
REQ-035 LOAD_LAT=3, memread_e rd_e=7, rs_d[1]=7 used -> stall_f/stall_d/flush_e high exactly 3 cycles, then 0.
REQ-036 mc_issue mc_rd=9; rs_d[0]=9 -> stall until cycle after mc_wb mc_wb_rd=9, sb_busy[9] 1 then 0.
REQ-037 Load-use stall with branch_taken_e=1 same cycle -> flush_d=flush_e=1, stall 0, FSM IDLE next cycle.
REQ-038 rst pulse in 2nd LD_STALL cycle with sb_busy[9]=1 -> all controls 0, sb_busy=0 after release.
REQ-039 mc_issue rd=4 and mc_wb rd=4 same cycle -> sb_busy[4]=1; mc_issue rd=0 -> sb_busy unchanged.
